// File: rtl/dptr_xmem_ctrl.sv
// Data pointer (DPH:DPL) owner and MOVX external memory bus sequencer.
// Define XMEM_READY_EN to add the xmem_ready wait-request input.
module dptr_xmem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  SFR_DPL     = 8'h82,
  parameter logic [7:0]  SFR_DPH     = 8'h83
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  output logic        op_ready,
  input  logic [15:0] imm,
  input  logic [7:0]  acc_in,
  input  logic        wr,
  input  logic        wr_bit,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_h,
  output logic [7:0]  data_l,
  output logic [15:0] xmem_addr,
  output logic [7:0]  xmem_wdata,
  input  logic [7:0]  xmem_rdata,
`ifdef XMEM_READY_EN
  input  logic        xmem_ready,
`endif
  output logic        xmem_rd,
  output logic        xmem_wr,
  output logic [7:0]  rd_data,
  output logic        done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_XRD  = 3'd3;
  localparam logic [2:0] OP_XWR  = 3'd4;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] cnt;
  logic       is_wr;
  logic       accept;
  logic       bus_op;
  logic       last;
  logic       bus_ready;
  logic       strobe_end;
  logic       sfr_dpl;
  logic       sfr_dph;

`ifdef XMEM_READY_EN
  assign bus_ready = xmem_ready;
`else
  assign bus_ready = 1'b1;
`endif

  always_comb begin
    accept     = op_valid && op_ready;
    bus_op     = (op_code == OP_XRD) || (op_code == OP_XWR);
    last       = (cnt == LAST_CNT);
    strobe_end = last && bus_ready;
    sfr_dpl    = wr && !wr_bit && (addr == SFR_DPL);
    sfr_dph    = wr && !wr_bit && (addr == SFR_DPH);
    state_nxt  = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = bus_op ? S_SETUP : S_DONE;
      S_SETUP:  state_nxt = S_STROBE;
      S_STROBE: if (strobe_end) state_nxt = S_HOLD;
      S_HOLD:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_wr      <= 1'b0;
      op_ready   <= 1'b1;
      done       <= 1'b0;
      xmem_rd    <= 1'b0;
      xmem_wr    <= 1'b0;
      xmem_addr  <= '0;
      xmem_wdata <= '0;
      rd_data    <= '0;
      data_h     <= '0;
      data_l     <= '0;
    end else begin
      state    <= state_nxt;
      op_ready <= (state_nxt == S_IDLE);
      done     <= (state_nxt == S_DONE);
      xmem_rd  <= (state_nxt == S_STROBE) && !is_wr;
      xmem_wr  <= (state_nxt == S_STROBE) && is_wr;

      if (state != S_STROBE) cnt <= '0;
      else if (!last)        cnt <= cnt + 3'd1;

      if (accept && bus_op) begin
        xmem_addr <= {data_h, data_l};
        is_wr     <= (op_code == OP_XWR);
        if (op_code == OP_XWR) xmem_wdata <= acc_in;
      end

      if ((state == S_STROBE) && strobe_end && !is_wr) rd_data <= xmem_rdata;

      // An accepted INC/LOAD takes priority over a same-cycle SFR write.
      if (accept && (op_code == OP_INC)) begin
        {data_h, data_l} <= {data_h, data_l} + 16'd1;
      end else if (accept && (op_code == OP_LOAD)) begin
        {data_h, data_l} <= imm;
      end else begin
        if (sfr_dpl) data_l <= data_in;
        if (sfr_dph) data_h <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_dptr_xmem_ctrl.sv
// Self-checking bench for dptr_xmem_ctrl: directed scenarios plus randomized ops
// checked against a behavioural model of DPTR, bus latency and read data.
module tb_dptr_xmem_ctrl;
  localparam int unsigned WAIT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_ready;
  logic [15:0] imm;
  logic [7:0]  acc_in;
  logic        wr, wr_bit;
  logic [7:0]  addr, data_in;
  logic [7:0]  data_h, data_l;
  logic [15:0] xmem_addr;
  logic [7:0]  xmem_wdata, xmem_rdata;
  logic        xmem_ready;
  logic        xmem_rd, xmem_wr;
  logic [7:0]  rd_data;
  logic        done;

  dptr_xmem_ctrl #(.WAIT_CYCLES(WAIT), .SFR_DPL(8'h82), .SFR_DPH(8'h83)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .imm(imm), .acc_in(acc_in), .wr(wr), .wr_bit(wr_bit),
    .addr(addr), .data_in(data_in), .data_h(data_h), .data_l(data_l),
    .xmem_addr(xmem_addr), .xmem_wdata(xmem_wdata), .xmem_rdata(xmem_rdata),
`ifdef XMEM_READY_EN
    .xmem_ready(xmem_ready),
`endif
    .xmem_rd(xmem_rd), .xmem_wr(xmem_wr), .rd_data(rd_data), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_dptr, m_addr;
  logic [7:0]  m_rd, m_wdata;
  int          m_lat;

  int          r_lat, r_rd_hi, r_wr_hi, r_addr_bad;
  logic [7:0]  r_wdata;
  logic        r_ready_done;

  task automatic model_reset();
    m_dptr = '0; m_addr = '0; m_rd = '0; m_wdata = '0;
  endtask

  task automatic model_op(input logic [2:0] code, input logic [15:0] iv, input logic [7:0] av,
                          input logic [7:0] rv, input int sfr_at, input logic [7:0] sa,
                          input logic [7:0] sv, input logic sb, input int stall);
    bit is_bus, sfr_ok;
    is_bus = (code == 3) || (code == 4);
    m_lat  = is_bus ? int'(WAIT) + 4 + stall : 1;
    if (is_bus) m_addr = m_dptr;
    if (code == 3) m_rd = rv;
    if (code == 4) m_wdata = av;
    sfr_ok = (sfr_at >= 0) && (sfr_at < m_lat) && !sb;
    if (sfr_at == 0 && (code == 1 || code == 2)) sfr_ok = 0;
    if (code == 1) m_dptr = m_dptr + 16'd1;
    if (code == 2) m_dptr = iv;
    if (sfr_ok && sa == 8'h82) m_dptr[7:0] = sv;
    if (sfr_ok && sa == 8'h83) m_dptr[15:8] = sv;
  endtask

  task automatic run_op(input logic [2:0] code, input logic [15:0] iv, input logic [7:0] av,
                        input logic [7:0] rv, input int sfr_at, input logic [7:0] sa,
                        input logic [7:0] sv, input logic sb, input int ready_low_until,
                        input logic [15:0] exp_addr);
    int k;
    @(negedge clock);
    op_valid = 1'b1; op_code = code; imm = iv; acc_in = av; xmem_rdata = rv;
    wr = (sfr_at == 0); wr_bit = sb; addr = sa; data_in = sv;
    xmem_ready = (ready_low_until <= 0);
    r_lat = -1; r_rd_hi = 0; r_wr_hi = 0; r_addr_bad = 0; r_wdata = 'x; r_ready_done = 1'bx;
    k = 0;
    while (k < 60 && r_lat < 0) begin
      @(negedge clock);
      k++;
      op_valid = 1'b0;
      if (xmem_rd === 1'b1) r_rd_hi++;
      if (xmem_wr === 1'b1) begin r_wr_hi++; r_wdata = xmem_wdata; end
      if ((xmem_rd === 1'b1 || xmem_wr === 1'b1) && xmem_addr !== exp_addr) r_addr_bad++;
      if (done === 1'b1) begin
        r_lat = k; r_ready_done = op_ready; wr = 1'b0;
      end else begin
        wr = (sfr_at == k);
        xmem_ready = (k >= ready_low_until);
      end
    end
    wr = 1'b0; xmem_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 0; op_code = 0; imm = 0; acc_in = 0; wr = 0; wr_bit = 0;
    addr = 0; data_in = 0; xmem_rdata = 0; xmem_ready = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({data_h, data_l, xmem_addr, xmem_wdata, rd_data, xmem_rd, xmem_wr, done, op_ready}
        !== {16'h0, 16'h0, 8'h0, 8'h0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_values: got dptr=%h xa=%h wd=%h rd=%h rd/wr/done/ready=%b%b%b%b, want zeros and ready=1",
               {data_h, data_l}, xmem_addr, xmem_wdata, rd_data, xmem_rd, xmem_wr, done, op_ready);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sfr_write();
    run_op(0, 0, 0, 0, 0, 8'h82, 8'h34, 0, 0, 0); model_op(0, 0, 0, 0, 0, 8'h82, 8'h34, 0, 0);
    run_op(0, 0, 0, 0, 0, 8'h83, 8'h12, 0, 0, 0); model_op(0, 0, 0, 0, 0, 8'h83, 8'h12, 0, 0);
    checks++;
    if ({data_h, data_l} !== 16'h1234) begin
      errors++; $display("FAIL sfr_write: got %h want 1234", {data_h, data_l});
    end
    run_op(0, 0, 0, 0, 0, 8'h82, 8'hFF, 1, 0, 0); model_op(0, 0, 0, 0, 0, 8'h82, 8'hFF, 1, 0);
    checks++;
    if (data_l !== 8'h34) begin
      errors++; $display("FAIL sfr_bit_write: data_l got %h want 34", data_l);
    end
  endtask

  task automatic test_inc_wrap();
    run_op(2, 16'hFFFF, 0, 0, -1, 0, 0, 0, 0, 0); model_op(2, 16'hFFFF, 0, 0, -1, 0, 0, 0, 0);
    checks++;
    if (r_lat !== 1 || {data_h, data_l} !== 16'hFFFF) begin
      errors++; $display("FAIL load_ffff: lat=%0d dptr=%h want lat=1 dptr=ffff", r_lat, {data_h, data_l});
    end
    run_op(1, 0, 0, 0, -1, 0, 0, 0, 0, 0); model_op(1, 0, 0, 0, -1, 0, 0, 0, 0);
    checks++;
    if (r_lat !== 1 || {data_h, data_l} !== 16'h0000 || r_ready_done !== 1'b0) begin
      errors++; $display("FAIL inc_wrap: lat=%0d dptr=%h ready@done=%b want lat=1 dptr=0000 ready=0",
                         r_lat, {data_h, data_l}, r_ready_done);
    end
  endtask

  task automatic test_xrd();
    run_op(2, 16'h1234, 0, 0, -1, 0, 0, 0, 0, 0); model_op(2, 16'h1234, 0, 0, -1, 0, 0, 0, 0);
    run_op(3, 0, 0, 8'hA5, -1, 0, 0, 0, 0, 16'h1234); model_op(3, 0, 0, 8'hA5, -1, 0, 0, 0, 0);
    checks++;
    if (r_lat !== 5 || r_rd_hi !== 2 || r_wr_hi !== 0 || r_addr_bad !== 0) begin
      errors++; $display("FAIL xrd_timing: lat=%0d rd_hi=%0d wr_hi=%0d addr_bad=%0d want 5 2 0 0",
                         r_lat, r_rd_hi, r_wr_hi, r_addr_bad);
    end
    checks++;
    if (rd_data !== 8'hA5 || xmem_addr !== 16'h1234) begin
      errors++; $display("FAIL xrd_data: rd_data=%h xmem_addr=%h want a5 1234", rd_data, xmem_addr);
    end
  endtask

  task automatic test_xwr_sfr();
    run_op(2, 16'h0010, 0, 0, -1, 0, 0, 0, 0, 0); model_op(2, 16'h0010, 0, 0, -1, 0, 0, 0, 0);
    run_op(4, 0, 8'h5A, 0, 2, 8'h82, 8'h99, 0, 0, 16'h0010); model_op(4, 0, 8'h5A, 0, 2, 8'h82, 8'h99, 0, 0);
    checks++;
    if (r_addr_bad !== 0 || r_wdata !== 8'h5A || r_wr_hi !== 2 || xmem_addr !== 16'h0010) begin
      errors++; $display("FAIL xwr_bus: addr_bad=%0d wdata=%h wr_hi=%0d xa=%h want 0 5a 2 0010",
                         r_addr_bad, r_wdata, r_wr_hi, xmem_addr);
    end
    checks++;
    if ({data_h, data_l} !== 16'h0099) begin
      errors++; $display("FAIL xwr_sfr: dptr=%h want 0099", {data_h, data_l});
    end
  endtask

  task automatic test_conflict();
    run_op(2, 16'h00FF, 0, 0, -1, 0, 0, 0, 0, 0); model_op(2, 16'h00FF, 0, 0, -1, 0, 0, 0, 0);
    run_op(1, 0, 0, 0, 0, 8'h82, 8'h77, 0, 0, 0); model_op(1, 0, 0, 0, 0, 8'h82, 8'h77, 0, 0);
    checks++;
    if ({data_h, data_l} !== 16'h0100) begin
      errors++; $display("FAIL conflict_inc: dptr=%h want 0100", {data_h, data_l});
    end
    run_op(2, 16'hBEEF, 0, 0, 0, 8'h83, 8'h11, 0, 0, 0); model_op(2, 16'hBEEF, 0, 0, 0, 8'h83, 8'h11, 0, 0);
    checks++;
    if ({data_h, data_l} !== 16'hBEEF) begin
      errors++; $display("FAIL conflict_load: dptr=%h want beef", {data_h, data_l});
    end
  endtask

`ifdef XMEM_READY_EN
  task automatic test_ready();
    run_op(3, 0, 0, 8'h3C, -1, 0, 0, 0, 6, m_dptr); model_op(3, 0, 0, 8'h3C, -1, 0, 0, 0, 3);
    checks++;
    if (r_lat !== int'(WAIT) + 7 || r_rd_hi !== int'(WAIT) + 4 || rd_data !== 8'h3C) begin
      errors++; $display("FAIL ready_stall: lat=%0d rd_hi=%0d rd=%h want %0d %0d 3c",
                         r_lat, r_rd_hi, rd_data, WAIT + 7, WAIT + 4);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0]  code;
    logic [15:0] iv, pre;
    logic [7:0]  av, rv, sa, sv;
    logic        sb;
    int          sat;
    for (int n = 0; n < 80; n++) begin
      code = 3'($urandom_range(0, 7));
      iv = 16'($urandom); av = 8'($urandom); rv = 8'($urandom); sv = 8'($urandom);
      case ($urandom_range(0, 3))
        0: sa = 8'h82;
        1: sa = 8'h83;
        2: sa = 8'h84;
        default: sa = 8'($urandom);
      endcase
      sb = ($urandom_range(0, 3) == 0);
      sat = int'($urandom_range(0, 7)) - 1;
      pre = m_dptr;
      run_op(code, iv, av, rv, sat, sa, sv, sb, 0, pre);
      model_op(code, iv, av, rv, sat, sa, sv, sb, 0);
      checks++;
      if (r_lat !== m_lat || r_rd_hi !== ((code == 3) ? int'(WAIT) + 1 : 0) ||
          r_wr_hi !== ((code == 4) ? int'(WAIT) + 1 : 0) || r_addr_bad !== 0 || r_ready_done !== 1'b0) begin
        errors++; $display("FAIL rand_timing[%0d] op=%0d: lat=%0d rd_hi=%0d wr_hi=%0d addr_bad=%0d ready=%b want lat=%0d",
                           n, code, r_lat, r_rd_hi, r_wr_hi, r_addr_bad, r_ready_done, m_lat);
      end
      checks++;
      if ({data_h, data_l} !== m_dptr || rd_data !== m_rd || xmem_addr !== m_addr || xmem_wdata !== m_wdata) begin
        errors++; $display("FAIL rand_state[%0d] op=%0d: dptr=%h rd=%h xa=%h wd=%h want %h %h %h %h",
                           n, code, {data_h, data_l}, rd_data, xmem_addr, xmem_wdata, m_dptr, m_rd, m_addr, m_wdata);
      end
    end
  endtask

  task automatic test_reset_mid_xrd();
    run_op(2, 16'h4321, 0, 0, -1, 0, 0, 0, 0, 0); model_op(2, 16'h4321, 0, 0, -1, 0, 0, 0, 0);
    @(negedge clock);
    op_valid = 1'b1; op_code = 3'd3; xmem_rdata = 8'h66;
    @(negedge clock);
    op_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (xmem_rd !== 1'b1) begin
      errors++; $display("FAIL reset_pre_strobe: xmem_rd=%b want 1", xmem_rd);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({data_h, data_l, xmem_addr, xmem_wdata, rd_data, xmem_rd, xmem_wr, done, op_ready}
        !== {16'h0, 16'h0, 8'h0, 8'h0, 4'b0001}) begin
      errors++; $display("FAIL reset_mid_xrd: dptr=%h xa=%h rd=%h rd/wr/done/ready=%b%b%b%b want zeros ready=1",
                         {data_h, data_l}, xmem_addr, rd_data, xmem_rd, xmem_wr, done, op_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || xmem_rd !== 1'b0) begin
        errors++; $display("FAIL reset_no_done[%0d]: done=%b xmem_rd=%b want 0 0", i, done, xmem_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sfr_write();
    test_inc_wrap();
    test_xrd();
    test_xwr_sfr();
    test_conflict();
`ifdef XMEM_READY_EN
    test_ready();
`endif
    test_random();
    test_reset_mid_xrd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
